sram_port_arbiter: RTL and testbench
====================================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter TAG_DEPTH, default 4: maximum number of reads outstanding at the SRAM controller; must be a power of two, 2..16.
REQ-002 Parameter STARVE_LIMIT, default 16: number of consecutive read grants after which a waiting write is forced.
REQ-003 The block SHALL use one clock and one reset. Port clock is the single clock. Port reset is synchronous and active-high.
REQ-004 Ports, as name, direction, width, meaning:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- w0_din_valid / w1_din_valid  in  1  write request.
- w0_din / w1_din  in  54  {mask[53:50], addr[49:32], data[31:0]}.
- w0_din_ready / w1_din_ready  out  1  write accepted this cycle.
- r0_din_valid / r1_din_valid  in  1  read request.
- r0_din / r1_din  in  18  read address.
- r0_din_ready / r1_din_ready  out  1  read accepted this cycle.
- r0_dout / r1_dout  out  32  read data.
- r0_dout_valid / r1_dout_valid  out  1  one-cycle pulse, read data valid.
- sram_addr_valid  out  1  command issued to SRAM controller.
- sram_ready  in  1  SRAM controller accepts a command.
- sram_addr  out  18  command address.
- sram_data_in  out  32  write data.
- sram_write_mask  out  4  byte enables; 4'h0 = read.
- sram_data_out  in  32  returned read data.
- sram_data_out_valid  in  1  returned data valid, in issue order.
- err_orphan  out  1  sticky flag: read data returned with no outstanding tag.

Function
REQ-005 Ports are arbitrated in round-robin order r0, r1, w0, w1 using a 2-bit pointer; after each grant the pointer SHALL advance to the port following the granted one.
REQ-006 The eligible set SHALL be: ports with valid asserted; reads SHALL be excluded when the outstanding-tag count equals TAG_DEPTH.
REQ-007 When sram_ready=1 and the eligible set is non-empty, exactly one port SHALL be granted, combinationally, in the same cycle.
REQ-008 The granted port's ready output SHALL be 1 in that cycle, and all other ready outputs SHALL be 0.
REQ-009 No ready output SHALL be asserted while sram_ready=0, and none while reset=1.
REQ-010 On a read grant the block SHALL drive sram_addr_valid=1, sram_addr=rN_din, sram_write_mask=4'h0, sram_data_in=0.
REQ-011 On a read grant the block SHALL push the port id (0/1) into the tag FIFO at the clock edge.
REQ-012 On a write grant with a non-zero mask the block SHALL drive sram_addr_valid=1 with the addr, data and mask fields taken from wN_din.
REQ-013 A write with mask 4'h0 SHALL be accepted (ready=1) and dropped: sram_addr_valid=0 and no tag pushed. The round-robin pointer SHALL still advance.
REQ-014 Starvation counter: it SHALL increment on each read grant while any write valid is pending, and clear on any write grant.
REQ-015 When the starvation counter reaches STARVE_LIMIT, reads SHALL be ineligible until a write is granted.
REQ-016 When sram_data_out_valid=1 and the tag FIFO is non-empty, the block SHALL pop the head tag.
REQ-017 On that pop, in the next cycle the block SHALL drive r<tag>_dout=sram_data_out and pulse r<tag>_dout_valid for one cycle; the other dout_valid SHALL stay 0.
REQ-018 Data latency from sram_data_out_valid to rN_dout_valid SHALL be exactly 1 cycle. There is no backpressure on the dout outputs.
REQ-019 A push and a pop in the same cycle SHALL both take effect, leaving the count unchanged.
REQ-020 A read SHALL NOT be granted at count==TAG_DEPTH even if a pop occurs in the same cycle.
REQ-021 When sram_data_out_valid=1 with the tag FIFO empty, the data SHALL be discarded and err_orphan set to 1 until reset.
REQ-022 All sram_* outputs SHALL be 0 whenever no grant occurs.

Reset
REQ-023 While reset=1, the following SHALL apply:
- round-robin pointer = r0.
- starvation counter = 0.
- tag FIFO emptied (count 0).
- r0_dout/r1_dout = 0 and r0_dout_valid/r1_dout_valid = 0.
- err_orphan = 0.
- all ready outputs = 0 and sram_addr_valid = 0.
REQ-024 Reset asserted mid-operation SHALL discard all outstanding tags. sram_data_out_valid pulses that arrive while reset=1 SHALL be ignored without setting err_orphan.

Verification
REQ-025 Scenario: sram_ready=1, and r0 and w0 both continuously valid, with w0 mask=4'hF, addr=18'h00010, data=32'hDEADBEEF. Required response: grants alternate r0, w0, r0, w0; each w0 grant drives sram_addr=18'h00010, sram_data_in=32'hDEADBEEF, sram_write_mask=4'hF.
REQ-026 Scenario: r1 is valid for 6 cycles while the SRAM returns no data. Required response: exactly 4 grants, then r1_din_ready=0. One sram_data_out_valid with data 32'h12345678 then produces r1_dout=32'h12345678 with r1_dout_valid high one cycle later, and a 5th read is granted in the cycle after the pop.
REQ-027 Scenario: reads r0, r1, r0 are issued, then three data_out_valid pulses carrying A, B, C. Required response: r0 receives A, r1 receives B, r0 receives C, each with 1-cycle latency.
REQ-028 Scenario: STARVE_LIMIT=4, r0 and r1 always valid, w1 raised while the counter is at 0. Required response: w1 is granted no later than the 5th grant after w1 is raised, and the counter is 0 after that grant.
REQ-029 Scenario: a w0 write with mask 4'h0. Required response: w0_din_ready=1 and sram_addr_valid=0 in the same cycle, and the pointer moves to w1.
REQ-030 Scenario: 2 reads are outstanding, reset is pulsed for 1 cycle, then sram_data_out_valid=1. Required response: no dout_valid pulse, err_orphan=1.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin arbiter of two read and two write ports onto one SRAM controller,
// routing returned read data back to its requester via an in-order tag FIFO.
module sram_port_arbiter #(
    parameter int TAG_DEPTH    = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        w0_din_valid,
    input  logic [53:0] w0_din,
    output logic        w0_din_ready,
    input  logic        w1_din_valid,
    input  logic [53:0] w1_din,
    output logic        w1_din_ready,
    input  logic        r0_din_valid,
    input  logic [17:0] r0_din,
    output logic        r0_din_ready,
    input  logic        r1_din_valid,
    input  logic [17:0] r1_din,
    output logic        r1_din_ready,
    output logic [31:0] r0_dout,
    output logic        r0_dout_valid,
    output logic [31:0] r1_dout,
    output logic        r1_dout_valid,
    output logic        sram_addr_valid,
    input  logic        sram_ready,
    output logic [17:0] sram_addr,
    output logic [31:0] sram_data_in,
    output logic [3:0]  sram_write_mask,
    input  logic [31:0] sram_data_out,
    input  logic        sram_data_out_valid,
    output logic        err_orphan
);
    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = $clog2(TAG_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [1:0]    ptr;
    logic [SW-1:0] starve_cnt;
    logic          tags [TAG_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          rd_ok;
    logic [3:0]    elig;
    logic [3:0]    gnt;
    logic [1:0]    gidx;
    logic          is_read;
    logic          is_write;
    logic          issue;
    logic          push;
    logic          pop;
    logic          pop_tag;
    logic [53:0]   w_sel;

    // Eligibility uses the registered count, so a same-cycle pop never frees a slot early.
    assign rd_ok = (count != CW'(TAG_DEPTH)) && (starve_cnt < SW'(STARVE_LIMIT));
    assign elig  = {w1_din_valid, w0_din_valid, r1_din_valid && rd_ok, r0_din_valid && rd_ok}
                   & {4{sram_ready && !reset}};

    always_comb begin
        gidx = ptr;
        for (int i = 3; i >= 0; i--) gidx = elig[ptr + 2'(i)] ? ptr + 2'(i) : gidx;
        gnt = |elig ? 4'b0001 << gidx : 4'b0000;
    end

    assign is_read  = gnt[0] | gnt[1];
    assign is_write = gnt[2] | gnt[3];
    assign w_sel    = gnt[3] ? w1_din : w0_din;
    assign issue    = is_read || (is_write && |w_sel[53:50]);
    assign push     = is_read;
    assign pop      = sram_data_out_valid && (count != '0);
    assign pop_tag  = tags[head];

    assign r0_din_ready    = gnt[0];
    assign r1_din_ready    = gnt[1];
    assign w0_din_ready    = gnt[2];
    assign w1_din_ready    = gnt[3];
    assign sram_addr_valid = issue;
    assign sram_addr       = !issue ? 18'h0 : is_read ? (gnt[1] ? r1_din : r0_din) : w_sel[49:32];
    assign sram_data_in    = (issue && is_write) ? w_sel[31:0] : 32'h0;
    assign sram_write_mask = (issue && is_write) ? w_sel[53:50] : 4'h0;

    always_ff @(posedge clock) begin
        if (push) tags[tail] <= gnt[1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr           <= 2'd0;
            starve_cnt    <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            r0_dout       <= 32'h0;
            r1_dout       <= 32'h0;
            r0_dout_valid <= 1'b0;
            r1_dout_valid <= 1'b0;
            err_orphan    <= 1'b0;
        end else begin
            if (|gnt) ptr <= gidx + 2'd1;
            if (is_write) starve_cnt <= '0;
            else if (is_read && (w0_din_valid || w1_din_valid)) starve_cnt <= starve_cnt + SW'(1);
            if (push) tail <= tail + PW'(1);
            if (pop) head <= head + PW'(1);
            count         <= count + CW'(push) - CW'(pop);
            r0_dout_valid <= pop && !pop_tag;
            r1_dout_valid <= pop && pop_tag;
            if (pop && !pop_tag) r0_dout <= sram_data_out;
            if (pop && pop_tag) r1_dout <= sram_data_out;
            if (sram_data_out_valid && count == '0) err_orphan <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed scenario tests for sram_port_arbiter with hand-computed expectations.
module tb_sram_port_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        w0_din_valid = 1'b0, w1_din_valid = 1'b0;
    logic [53:0] w0_din = '0, w1_din = '0;
    logic        w0_din_ready, w1_din_ready;
    logic        r0_din_valid = 1'b0, r1_din_valid = 1'b0;
    logic [17:0] r0_din = '0, r1_din = '0;
    logic        r0_din_ready, r1_din_ready;
    logic [31:0] r0_dout, r1_dout;
    logic        r0_dout_valid, r1_dout_valid;
    logic        sram_addr_valid;
    logic        sram_ready = 1'b0;
    logic [17:0] sram_addr;
    logic [31:0] sram_data_in;
    logic [3:0]  sram_write_mask;
    logic [31:0] sram_data_out = '0;
    logic        sram_data_out_valid = 1'b0;
    logic        err_orphan;
    int          checks = 0;
    int          errors = 0;

    sram_port_arbiter #(.TAG_DEPTH(4), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .w0_din_valid(w0_din_valid), .w0_din(w0_din), .w0_din_ready(w0_din_ready),
        .w1_din_valid(w1_din_valid), .w1_din(w1_din), .w1_din_ready(w1_din_ready),
        .r0_din_valid(r0_din_valid), .r0_din(r0_din), .r0_din_ready(r0_din_ready),
        .r1_din_valid(r1_din_valid), .r1_din(r1_din), .r1_din_ready(r1_din_ready),
        .r0_dout(r0_dout), .r0_dout_valid(r0_dout_valid),
        .r1_dout(r1_dout), .r1_dout_valid(r1_dout_valid),
        .sram_addr_valid(sram_addr_valid), .sram_ready(sram_ready), .sram_addr(sram_addr),
        .sram_data_in(sram_data_in), .sram_write_mask(sram_write_mask),
        .sram_data_out(sram_data_out), .sram_data_out_valid(sram_data_out_valid),
        .err_orphan(err_orphan)
    );

    always #5 clock = ~clock;

    task automatic idle_inputs();
        w0_din_valid = 0; w1_din_valid = 0; r0_din_valid = 0; r1_din_valid = 0;
        sram_data_out_valid = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        idle_inputs();
        reset = 1;
        @(negedge clock);
        reset = 0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1; sram_ready = 1; r0_din_valid = 1; w0_din_valid = 1;
        w0_din = {4'hF, 18'h00010, 32'h1}; sram_data_out_valid = 1;
        #1;
        checks++; if (r0_din_ready !== 1'b0) begin errors++; $display("FAIL reset_r0_ready: got %b want 0", r0_din_ready); end
        checks++; if (w0_din_ready !== 1'b0) begin errors++; $display("FAIL reset_w0_ready: got %b want 0", w0_din_ready); end
        checks++; if (sram_addr_valid !== 1'b0) begin errors++; $display("FAIL reset_addr_valid: got %b want 0", sram_addr_valid); end
        @(negedge clock);
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_orphan: got %b want 0", err_orphan); end
        checks++; if ({r0_dout_valid, r1_dout_valid} !== 2'b00) begin errors++; $display("FAIL reset_dout_valid: got %b want 00", {r0_dout_valid, r1_dout_valid}); end
        checks++; if (r0_dout !== 32'h0) begin errors++; $display("FAIL reset_r0_dout: got %h want 0", r0_dout); end
        idle_inputs();
        reset = 0;
    endtask

    task automatic test_no_sram_ready();
        do_reset();
        sram_ready = 0; r0_din_valid = 1; r0_din = 18'h00055;
        #1;
        checks++; if (r0_din_ready !== 1'b0) begin errors++; $display("FAIL noready_r0: got %b want 0", r0_din_ready); end
        checks++; if ({sram_addr_valid, sram_addr} !== 19'h0) begin errors++; $display("FAIL noready_sram: got %h want 0", {sram_addr_valid, sram_addr}); end
        @(negedge clock);
        idle_inputs();
        sram_ready = 1;
    endtask

    task automatic test_alternate();
        do_reset();
        r0_din_valid = 1; r0_din = 18'h00100;
        w0_din_valid = 1; w0_din = {4'hF, 18'h00010, 32'hDEADBEEF};
        for (int k = 0; k < 4; k++) begin
            #1;
            if (k % 2 == 0) begin
                checks++; if ({r0_din_ready, w0_din_ready} !== 2'b10) begin errors++; $display("FAIL alt_grant_r0[%0d]: got %b want 10", k, {r0_din_ready, w0_din_ready}); end
                checks++; if ({sram_addr, sram_write_mask} !== {18'h00100, 4'h0}) begin errors++; $display("FAIL alt_read_cmd[%0d]: got %h/%h want 00100/0", k, sram_addr, sram_write_mask); end
            end else begin
                checks++; if ({r0_din_ready, w0_din_ready} !== 2'b01) begin errors++; $display("FAIL alt_grant_w0[%0d]: got %b want 01", k, {r0_din_ready, w0_din_ready}); end
                checks++; if ({sram_addr, sram_data_in, sram_write_mask} !== {18'h00010, 32'hDEADBEEF, 4'hF}) begin errors++; $display("FAIL alt_write_cmd[%0d]: got %h/%h/%h want 00010/deadbeef/f", k, sram_addr, sram_data_in, sram_write_mask); end
            end
            @(negedge clock);
        end
        idle_inputs();
    endtask

    task automatic test_tag_limit();
        do_reset();
        r1_din_valid = 1; r1_din = 18'h00200;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++; if (r1_din_ready !== (k < 4)) begin errors++; $display("FAIL tag_limit_ready[%0d]: got %b want %b", k, r1_din_ready, k < 4); end
            @(negedge clock);
        end
        sram_data_out_valid = 1; sram_data_out = 32'h12345678;
        #1;
        checks++; if (r1_din_ready !== 1'b0) begin errors++; $display("FAIL tag_full_pop_cycle: got %b want 0", r1_din_ready); end
        @(negedge clock);
        sram_data_out_valid = 0;
        #1;
        checks++; if ({r1_dout_valid, r0_dout_valid} !== 2'b10) begin errors++; $display("FAIL tag_pop_valid: got %b want 10", {r1_dout_valid, r0_dout_valid}); end
        checks++; if (r1_dout !== 32'h12345678) begin errors++; $display("FAIL tag_pop_data: got %h want 12345678", r1_dout); end
        checks++; if (r1_din_ready !== 1'b1) begin errors++; $display("FAIL tag_fifth_grant: got %b want 1", r1_din_ready); end
        @(negedge clock);
        idle_inputs();
        checks++; if (r1_dout_valid !== 1'b0) begin errors++; $display("FAIL tag_pulse_width: got %b want 0", r1_dout_valid); end
    endtask

    task automatic test_order();
        logic [31:0] vals [3];
        logic        port [3];
        vals = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};
        port = '{1'b0, 1'b1, 1'b0};
        do_reset();
        r0_din_valid = 1; r0_din = 18'h00001;
        #1;
        checks++; if (r0_din_ready !== 1'b1) begin errors++; $display("FAIL order_issue0: got %b want 1", r0_din_ready); end
        @(negedge clock);
        r0_din_valid = 0; r1_din_valid = 1; r1_din = 18'h00002;
        #1;
        checks++; if (r1_din_ready !== 1'b1) begin errors++; $display("FAIL order_issue1: got %b want 1", r1_din_ready); end
        @(negedge clock);
        r1_din_valid = 0; r0_din_valid = 1; r0_din = 18'h00003;
        #1;
        checks++; if (r0_din_ready !== 1'b1) begin errors++; $display("FAIL order_issue2: got %b want 1", r0_din_ready); end
        @(negedge clock);
        r0_din_valid = 0;
        for (int k = 0; k < 3; k++) begin
            sram_data_out_valid = 1; sram_data_out = vals[k];
            @(negedge clock);
            checks++; if ({r1_dout_valid, r0_dout_valid} !== (port[k] ? 2'b10 : 2'b01)) begin errors++; $display("FAIL order_valid[%0d]: got %b want %b", k, {r1_dout_valid, r0_dout_valid}, port[k] ? 2'b10 : 2'b01); end
            checks++; if ((port[k] ? r1_dout : r0_dout) !== vals[k]) begin errors++; $display("FAIL order_data[%0d]: got %h want %h", k, port[k] ? r1_dout : r0_dout, vals[k]); end
        end
        sram_data_out_valid = 0;
        @(negedge clock);
        checks++; if ({r1_dout_valid, r0_dout_valid, err_orphan} !== 3'b000) begin errors++; $display("FAIL order_idle: got %b want 000", {r1_dout_valid, r0_dout_valid, err_orphan}); end
    endtask

    task automatic test_starve();
        do_reset();
        r0_din_valid = 1; r1_din_valid = 1; r0_din = 18'h00011; r1_din = 18'h00022;
        w1_din_valid = 1; w1_din = {4'h3, 18'h00300, 32'hCAFEF00D};
        #1;
        checks++; if (r0_din_ready !== 1'b1) begin errors++; $display("FAIL starve_g1_r0: got %b want 1", r0_din_ready); end
        @(negedge clock);
        #1;
        checks++; if (r1_din_ready !== 1'b1) begin errors++; $display("FAIL starve_g2_r1: got %b want 1", r1_din_ready); end
        @(negedge clock);
        #1;
        checks++; if ({w1_din_ready, r0_din_ready, r1_din_ready} !== 3'b100) begin errors++; $display("FAIL starve_g3_w1: got %b want 100", {w1_din_ready, r0_din_ready, r1_din_ready}); end
        checks++; if ({sram_addr, sram_data_in, sram_write_mask} !== {18'h00300, 32'hCAFEF00D, 4'h3}) begin errors++; $display("FAIL starve_w1_cmd: got %h/%h/%h want 00300/cafef00d/3", sram_addr, sram_data_in, sram_write_mask); end
        @(negedge clock);
        w1_din_valid = 0;
        checks++; if (dut.starve_cnt !== '0) begin errors++; $display("FAIL starve_cnt_clear: got %0d want 0", dut.starve_cnt); end
        #1;
        checks++; if (r0_din_ready !== 1'b1) begin errors++; $display("FAIL starve_after_r0: got %b want 1", r0_din_ready); end
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic test_drop_write();
        do_reset();
        w0_din_valid = 1; w0_din = {4'h0, 18'h00040, 32'h55555555};
        #1;
        checks++; if ({w0_din_ready, sram_addr_valid} !== 2'b10) begin errors++; $display("FAIL drop_ready_valid: got %b want 10", {w0_din_ready, sram_addr_valid}); end
        checks++; if (sram_write_mask !== 4'h0) begin errors++; $display("FAIL drop_mask: got %h want 0", sram_write_mask); end
        @(negedge clock);
        w0_din_valid = 0; r0_din_valid = 1; w1_din_valid = 1; w1_din = {4'h1, 18'h00050, 32'h0000_00A5};
        #1;
        checks++; if ({w1_din_ready, r0_din_ready, sram_addr_valid} !== 3'b101) begin errors++; $display("FAIL drop_ptr_w1: got %b want 101", {w1_din_ready, r0_din_ready, sram_addr_valid}); end
        @(negedge clock);
        idle_inputs();
        sram_data_out_valid = 1; sram_data_out = 32'h77;
        @(negedge clock);
        sram_data_out_valid = 0;
        checks++; if ({err_orphan, r0_dout_valid, r1_dout_valid} !== 3'b100) begin errors++; $display("FAIL drop_no_tag_orphan: got %b want 100", {err_orphan, r0_dout_valid, r1_dout_valid}); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        r0_din_valid = 1;
        @(negedge clock);
        @(negedge clock);
        r0_din_valid = 0;
        reset = 1; sram_data_out_valid = 1; sram_data_out = 32'h99;
        r1_din_valid = 1;
        #1;
        checks++; if (r1_din_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %b want 0", r1_din_ready); end
        @(negedge clock);
        reset = 0; r1_din_valid = 0;
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL mid_reset_ignored: got %b want 0", err_orphan); end
        @(negedge clock);
        sram_data_out_valid = 0;
        checks++; if ({r0_dout_valid, r1_dout_valid, err_orphan} !== 3'b001) begin errors++; $display("FAIL mid_reset_orphan: got %b want 001", {r0_dout_valid, r1_dout_valid, err_orphan}); end
    endtask

    initial begin
        test_reset();
        test_no_sram_ready();
        test_alternate();
        test_tag_limit();
        test_order();
        test_starve();
        test_drop_write();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
